chan_mux_arb: RTL and testbench

//   Parametrised N-channel data-path multiplexer with valid/ready handshake, one registered output stage and
//   two selection modes: forced select (sel drives the choice, like the plain 2:1 muxes) or round-robin.
//   It merges several bus sources (ALU result, memory read, exception/cause data) onto one DATA_BUS_WIDTH

---
 rtl/chan_mux_arb_pkg.sv | 18 +
 rtl/chan_mux_arb_rr_arbiter.sv | 53 +++++
 rtl/chan_mux_arb.sv | 168 ++++++++++++++++
 tb/tb_chan_mux_arb.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chan_mux_arb_pkg.sv
// chan_mux_arb_pkg
//   Shared constants for the channel mux/arbiter slice. This package takes the place of
//   parameters.v for this block and holds the following:
//     DATA_BUS_WIDTH   payload width of the shared data bus
//     CHAN_MUX_NUM_CH  default number of mux channels
//     arb_mode_e       encoding of the arb_mode input (ARB_MODE_SEL=0, ARB_MODE_RR=1)
//   The package has no ports.
package chan_mux_arb_pkg;

  localparam int DATA_BUS_WIDTH  = 16;
  localparam int CHAN_MUX_NUM_CH = 4;

  typedef enum logic {
    ARB_MODE_SEL = 1'b0,
    ARB_MODE_RR  = 1'b1
  } arb_mode_e;

endpackage

// File: rtl/chan_mux_arb_rr_arbiter.sv
// rr_arbiter
//   This is a combinational round-robin arbiter. The pointer register is owned by the parent.
//   The arbiter scans req starting at ptr+1 and wraps from NUM_CH-1 back to 0.
//   Ports:
//     req        in   NUM_CH  request vector
//     advance    in   1       the parent accepted the granted request this cycle
//     ptr        in   SEL_W   index of the last round-robin winner
//     grant      out  NUM_CH  one-hot grant (all zero when there is no request)
//     grant_idx  out  SEL_W   index of the granted channel
//     grant_any  out  1       a request was found
//     next_ptr   out  SEL_W   pointer value for the parent to register
import chan_mux_arb_pkg::*;

module rr_arbiter #(
  parameter int NUM_CH = CHAN_MUX_NUM_CH,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic              advance,
  input  logic [SEL_W-1:0]  ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [SEL_W-1:0]  grant_idx,
  output logic              grant_any,
  output logic [SEL_W-1:0]  next_ptr
);

  logic [SEL_W:0] cand;

  // The first request after ptr wins. The sum is one bit wider so that ptr+off can wrap
  // with a single conditional subtract.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    for (int off = 1; off <= NUM_CH; off++) begin
      cand = {1'b0, ptr} + (SEL_W+1)'(off);
      if (cand >= (SEL_W+1)'(NUM_CH)) begin
        cand = cand - (SEL_W+1)'(NUM_CH);
      end
      if (!grant_any && req[cand[SEL_W-1:0]]) begin
        grant_any                = 1'b1;
        grant_idx                = cand[SEL_W-1:0];
        grant[cand[SEL_W-1:0]]   = 1'b1;
      end
    end
  end

  // This is kept outside the scan block. Advance depends on the grant through the parent's
  // transfer logic, so computing it here avoids a combinational loop.
  assign next_ptr = advance ? grant_idx : ptr;

endmodule

// File: rtl/chan_mux_arb.sv
// chan_mux_arb
//   This is an N-channel valid/ready data-path mux with one registered output stage.
//   arb_mode selects the arbitration: 0 uses forced select (sel), 1 uses round-robin.
//   Optional feature macro: CHAN_MUX_LOCK_EN. It adds in_last/out_last and makes a
//   round-robin grant stay locked to its channel until the last beat of a burst.
//   Ports:
//     clk, rst_n            clock (rising edge) and asynchronous active-low reset
//     in_data   in   NUM_CH*DATA_W  channel i payload at [i*DATA_W +: DATA_W]
//     in_valid  in   NUM_CH         per-channel valid
//     in_ready  out  NUM_CH         per-channel ready, at most one bit high
//     arb_mode  in   1              0 forced select, 1 round-robin
//     sel       in   SEL_W          channel used in forced-select mode
//     out_data  out  DATA_W         registered payload
//     out_chan  out  SEL_W          source channel of out_data
//     out_valid out  1              output beat held
//     out_ready in   1              consumer accepts the beat
//     in_last   in   NUM_CH         (CHAN_MUX_LOCK_EN) end of burst per channel
//     out_last  out  1              (CHAN_MUX_LOCK_EN) registered in_last of the held beat
import chan_mux_arb_pkg::*;

module chan_mux_arb #(
  parameter int DATA_W = DATA_BUS_WIDTH,
  parameter int NUM_CH = CHAN_MUX_NUM_CH,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic                     arb_mode,
  input  logic [SEL_W-1:0]         sel,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_chan,
  output logic                     out_valid,
  input  logic                     out_ready
`ifdef CHAN_MUX_LOCK_EN
  ,
  input  logic [NUM_CH-1:0]        in_last,
  output logic                     out_last
`endif
);

  logic              rr_mode;
  logic              load;
  logic              xfer;
  logic              sel_ok;
  logic [NUM_CH-1:0] sel_oh;
  logic              grant_any;
  logic [SEL_W-1:0]  grant_idx;
  logic [NUM_CH-1:0] grant_oh;
  logic [SEL_W-1:0]  rr_ptr;
  logic [SEL_W-1:0]  rr_next;
  logic [SEL_W-1:0]  rr_idx;
  logic [NUM_CH-1:0] rr_grant;
  logic              rr_any;
  logic              rr_advance;
  logic              lock_hold;

  assign rr_mode = (arb_mode == ARB_MODE_RR);

  // Decode sel against the real channel count. An out-of-range sel grants nothing.
  always_comb begin
    sel_ok = 1'b0;
    sel_oh = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel == SEL_W'(i)) begin
        sel_ok    = 1'b1;
        sel_oh[i] = 1'b1;
      end
    end
  end

`ifdef CHAN_MUX_LOCK_EN
  logic             locked;
  logic [SEL_W-1:0] lock_ch;

  assign lock_hold = rr_mode && locked;

  // A round-robin transfer with in_last=0 opens a burst. The burst holds the grant on its
  // channel until that channel's last beat goes through. Forced-select transfers leave the
  // lock alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked  <= 1'b0;
      lock_ch <= '0;
    end else if (xfer && rr_mode) begin
      locked  <= !in_last[grant_idx];
      lock_ch <= grant_idx;
    end
  end
`else
  assign lock_hold = 1'b0;
`endif

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W)
  ) u_rr (
    .req       (in_valid),
    .advance   (rr_advance),
    .ptr       (rr_ptr),
    .grant     (rr_grant),
    .grant_idx (rr_idx),
    .grant_any (rr_any),
    .next_ptr  (rr_next)
  );

  // Choose the grant source for this cycle. A locked burst is granted even while its
  // channel's valid is low.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    grant_oh  = '0;
    if (!rr_mode) begin
      grant_any = sel_ok;
      grant_idx = sel;
      grant_oh  = sel_oh;
    end
`ifdef CHAN_MUX_LOCK_EN
    else if (lock_hold) begin
      grant_any = 1'b1;
      grant_idx = lock_ch;
      grant_oh  = NUM_CH'(1) << lock_ch;
    end
`endif
    else begin
      grant_any = rr_any;
      grant_idx = rr_idx;
      grant_oh  = rr_grant;
    end
  end

  assign load     = !out_valid || out_ready;
  assign in_ready = (rst_n && load && grant_any) ? grant_oh : '0;
  assign xfer     = rst_n && load && grant_any && in_valid[grant_idx];

  // While a burst is locked, the pointer already sits on the locked channel.
  // Advancing is skipped because the arbiter's own pick may name a different channel.
  assign rr_advance = xfer && rr_mode && !lock_hold;

  // Output register: a transfer loads a new beat, and a consume with no transfer drains
  // the register. In every other case the held beat is frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      rr_ptr    <= SEL_W'(NUM_CH-1);
`ifdef CHAN_MUX_LOCK_EN
      out_last  <= 1'b0;
`endif
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= in_data[int'(grant_idx)*DATA_W +: DATA_W];
        out_chan  <= grant_idx;
`ifdef CHAN_MUX_LOCK_EN
        out_last  <= in_last[grant_idx];
`endif
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      rr_ptr <= rr_next;
    end
  end

endmodule

// File: tb/tb_chan_mux_arb.sv
// tb_chan_mux_arb
//   This is the self-checking bench for chan_mux_arb. It drives a 4-channel instance and a
//   3-channel instance. It runs a vector table, hand-written corner sequences and random
//   traffic against a reference model. Build with CHAN_MUX_LOCK_EN to cover the burst lock.
module tb_chan_mux_arb;
  import chan_mux_arb_pkg::*;

  localparam int N  = 4;
  localparam int DW = DATA_BUS_WIDTH;
  localparam int SW = 2;

  logic            clk;
  logic            rst_n;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic            arb_mode;
  logic [SW-1:0]   sel;
  logic [DW-1:0]   out_data;
  logic [SW-1:0]   out_chan;
  logic            out_valid;
  logic            out_ready;

  logic [3*DW-1:0] in_data3;
  logic [2:0]      in_valid3;
  logic [2:0]      in_ready3;
  logic            arb_mode3;
  logic [1:0]      sel3;
  logic [DW-1:0]   out_data3;
  logic [1:0]      out_chan3;
  logic            out_valid3;
  logic            out_ready3;

`ifdef CHAN_MUX_LOCK_EN
  logic [N-1:0] in_last;
  logic         out_last;
  logic [2:0]   in_last3;
  logic         out_last3;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic          m_valid;
  logic [DW-1:0] m_data;
  int            m_chan;
  int            m_ptr;
  logic          m_locked;
  int            m_lock;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  chan_mux_arb #(.DATA_W(DW), .NUM_CH(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .arb_mode  (arb_mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef CHAN_MUX_LOCK_EN
    ,
    .in_last   (in_last),
    .out_last  (out_last)
`endif
  );

  chan_mux_arb #(.DATA_W(DW), .NUM_CH(3)) dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data3),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .arb_mode  (arb_mode3),
    .sel       (sel3),
    .out_data  (out_data3),
    .out_chan  (out_chan3),
    .out_valid (out_valid3),
    .out_ready (out_ready3)
`ifdef CHAN_MUX_LOCK_EN
    ,
    .in_last   (in_last3),
    .out_last  (out_last3)
`endif
  );

  typedef struct {
    logic          mode;
    logic [1:0]    sel;
    logic [3:0]    valid;
    logic          ordy;
    logic [3:0]    exp_ready;
    logic          exp_valid;
    logic [1:0]    exp_chan;
    logic [15:0]   exp_data;
  } vec_t;

  vec_t tbl[12];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic m, input logic [SW-1:0] s, input logic [N-1:0] v,
                               input logic r);
    arb_mode  = m;
    sel       = s;
    in_valid  = v;
    out_ready = r;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(1'b0, '0, '0, 1'b0);
    arb_mode3  = 1'b0;
    sel3       = '0;
    in_valid3  = '0;
    out_ready3 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // The model picks the grant directly from the arbitration rules.
  function automatic int modelGrant();
    if (arb_mode == ARB_MODE_SEL) return (int'(sel) < N) ? int'(sel) : -1;
    if (m_locked) return m_lock;
    for (int off = 1; off <= N; off++) begin
      if (in_valid[(m_ptr + off) % N]) return (m_ptr + off) % N;
    end
    return -1;
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] sv [5];
    logic [3:0] lv [5];
    logic [3:0] er [5];
    logic       ev [5];
    int         ec [5];
    int         g;
    logic       ld;
    logic       xf;
    logic [3:0] exp_r;
    logic       cur_last;

    tbl[0]  = '{1'b0, 2'd2, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 16'hBEEF};
    tbl[1]  = '{1'b0, 2'd2, 4'b0000, 1'b1, 4'b0100, 1'b0, 2'd2, 16'hBEEF};
    tbl[2]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 16'h1111};
    tbl[3]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 16'h2222};
    tbl[4]  = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1, 16'h2222};
    tbl[5]  = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1, 16'h2222};
    tbl[6]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 16'hBEEF};
    tbl[7]  = '{1'b0, 2'd1, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 16'h2222};
    tbl[8]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 16'h4444};
    tbl[9]  = '{1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3, 16'h4444};
    tbl[10] = '{1'b1, 2'd0, 4'b0101, 1'b1, 4'b0001, 1'b1, 2'd0, 16'h1111};
    tbl[11] = '{1'b1, 2'd0, 4'b0101, 1'b1, 4'b0100, 1'b1, 2'd2, 16'hBEEF};

    in_data  = {16'h4444, 16'hBEEF, 16'h2222, 16'h1111};
    in_data3 = {16'h3333, 16'h2222, 16'h1111};
`ifdef CHAN_MUX_LOCK_EN
    in_last  = '1;
    in_last3 = '1;
`endif
    applyStimulus(1'b0, '0, 4'hF, 1'b1);
    arb_mode3 = 1'b0; sel3 = '0; in_valid3 = '0; out_ready3 = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("reset_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_data", 32'(out_data), 32'd0);
    checkOutput("reset_chan", 32'(out_chan), 32'd0);
    checkOutput("reset_ready", 32'(in_ready), 32'd0);

    // Table vectors
    doReset();
    for (int i = 0; i < 12; i++) begin
      applyStimulus(tbl[i].mode, tbl[i].sel, tbl[i].valid, tbl[i].ordy);
      @(negedge clk);
      checkOutput($sformatf("tbl%0d_ready", i), 32'(in_ready), 32'(tbl[i].exp_ready));
      @(posedge clk); #1;
      checkOutput($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].exp_valid));
      if (tbl[i].exp_valid) begin
        checkOutput($sformatf("tbl%0d_chan", i), 32'(out_chan), 32'(tbl[i].exp_chan));
        checkOutput($sformatf("tbl%0d_data", i), 32'(out_data), 32'(tbl[i].exp_data));
      end
    end

    // Round-robin over four always-valid channels: 0,1,2,3,0
    doReset();
    applyStimulus(1'b1, '0, 4'hF, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput($sformatf("rr%0d_ready", k), 32'(in_ready), 32'(4'b1 << (k % 4)));
      @(posedge clk); #1;
      checkOutput($sformatf("rr%0d_chan", k), 32'(out_chan), 32'(k % 4));
      checkOutput($sformatf("rr%0d_valid", k), 32'(out_valid), 32'd1);
    end

    // Stall with channel 0's beat held, then release
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_data = {$urandom, $urandom};
      @(negedge clk);
      checkOutput($sformatf("stall%0d_ready", k), 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      checkOutput($sformatf("stall%0d_data", k), 32'(out_data), 32'h1111);
      checkOutput($sformatf("stall%0d_chan", k), 32'(out_chan), 32'd0);
      checkOutput($sformatf("stall%0d_valid", k), 32'(out_valid), 32'd1);
    end
    in_data   = {16'h4444, 16'hBEEF, 16'h2222, 16'h1111};
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("release_ready", 32'(in_ready), 32'b0010);
    @(posedge clk); #1;
    checkOutput("release_chan", 32'(out_chan), 32'd1);
    checkOutput("release_data", 32'(out_data), 32'h2222);
    @(posedge clk); #1;
    checkOutput("release2_chan", 32'(out_chan), 32'd2);

    // Asynchronous reset mid-stream
    @(negedge clk);
    checkOutput("pre_areset_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("areset_valid", 32'(out_valid), 32'd0);
    checkOutput("areset_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    applyStimulus(1'b1, '0, 4'hF, 1'b1);
    @(posedge clk); #1;
    checkOutput("post_areset_chan", 32'(out_chan), 32'd0);
    @(posedge clk); #1;
    checkOutput("post_areset_chan2", 32'(out_chan), 32'd1);

    // Three-channel instance: out-of-range sel and idle round-robin
    doReset();
    arb_mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111; out_ready3 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput($sformatf("sel3oob%0d_ready", k), 32'(in_ready3), 32'd0);
      @(posedge clk); #1;
      checkOutput($sformatf("sel3oob%0d_valid", k), 32'(out_valid3), 32'd0);
    end
    arb_mode3 = 1'b1; in_valid3 = 3'b000;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checkOutput($sformatf("rr3idle%0d_ready", k), 32'(in_ready3), 32'd0);
      @(posedge clk); #1;
      checkOutput($sformatf("rr3idle%0d_valid", k), 32'(out_valid3), 32'd0);
    end
    in_valid3 = 3'b111;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("rr3wrap%0d_chan", k), 32'(out_chan3), 32'(k % 3));
    end
    arb_mode3 = 1'b0; sel3 = 2'd2;
    @(posedge clk); #1;
    checkOutput("sel3_chan", 32'(out_chan3), 32'd2);
    checkOutput("sel3_data", 32'(out_data3), 32'h3333);
    in_valid3 = '0;

`ifdef CHAN_MUX_LOCK_EN
    // Channel 1 sends a 3-beat burst and drops valid once; channel 2 waits for it
    doReset();
    sv = '{4'b0110, 4'b0100, 4'b0110, 4'b0110, 4'b0100};
    lv = '{4'b1100, 4'b1100, 4'b1100, 4'b1110, 4'b1110};
    er = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0100};
    ev = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    ec = '{1, 1, 1, 1, 2};
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, '0, sv[k], 1'b1);
      in_last = lv[k];
      @(negedge clk);
      checkOutput($sformatf("lock%0d_ready", k), 32'(in_ready), 32'(er[k]));
      @(posedge clk); #1;
      checkOutput($sformatf("lock%0d_valid", k), 32'(out_valid), 32'(ev[k]));
      if (ev[k]) checkOutput($sformatf("lock%0d_chan", k), 32'(out_chan), 32'(ec[k]));
    end
    checkOutput("lock_last", 32'(out_last), 32'd1);
    in_last = '1;
`endif

    // Random traffic against the reference model
    doReset();
    m_valid = 1'b0; m_data = '0; m_chan = 0; m_ptr = N - 1; m_locked = 1'b0; m_lock = 0;
    cur_last = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      applyStimulus(1'($urandom_range(0, 1)), SW'($urandom_range(0, 3)), N'($urandom),
                    ($urandom_range(0, 3) != 0));
      in_data = {$urandom, $urandom};
`ifdef CHAN_MUX_LOCK_EN
      in_last = N'($urandom);
`endif
      @(negedge clk);
      ld    = !m_valid || out_ready;
      g     = modelGrant();
      exp_r = (ld && g >= 0) ? (4'b1 << g) : 4'b0;
      xf    = ld && (g >= 0) && in_valid[g];
      checkOutput($sformatf("rnd%0d_ready", cyc), 32'(in_ready), 32'(exp_r));
      @(posedge clk); #1;
      if (xf) begin
        m_valid = 1'b1;
        m_data  = in_data[g*DW +: DW];
        m_chan  = g;
`ifdef CHAN_MUX_LOCK_EN
        cur_last = in_last[g];
        if (arb_mode == ARB_MODE_RR) begin
          m_locked = !in_last[g];
          m_lock   = g;
        end
`endif
        if (arb_mode == ARB_MODE_RR) m_ptr = g;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
      checkOutput($sformatf("rnd%0d_valid", cyc), 32'(out_valid), 32'(m_valid));
      if (m_valid) begin
        checkOutput($sformatf("rnd%0d_data", cyc), 32'(out_data), 32'(m_data));
        checkOutput($sformatf("rnd%0d_chan", cyc), 32'(out_chan), 32'(m_chan));
`ifdef CHAN_MUX_LOCK_EN
        checkOutput($sformatf("rnd%0d_last", cyc), 32'(out_last), 32'(cur_last));
`endif
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
